md_hilo_ctrl: RTL and testbench

//  Multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS pipeline.

---
 rtl/md_hilo_ctrl.sv | 139 +++++++++++++
 tb/tb_md_hilo_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO register owner.
// Models a fixed-latency MD unit; result lands in HI/LO after N busy cycles.
module md_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        done,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          start_md;
  logic          is_mthi;
  logic          is_mtlo;
  logic          sgn;
  logic [63:0]   prod;
  logic [31:0]   ua;
  logic [31:0]   ub;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign start_md = start & ~md_op[2] & (state == IDLE);
  assign is_mthi  = start & (md_op == 3'b100);
  assign is_mtlo  = start & (md_op == 3'b101);

  // Result of the offered op; divide goes through magnitudes so the
  // 0x80000000 / -1 case wraps cleanly instead of overflowing.
  always_comb begin
    prod   = '0;
    ua     = '0;
    ub     = '0;
    uq     = '0;
    ur     = '0;
    res_hi = '0;
    res_lo = '0;
    sgn    = ~md_op[0];
    if (!md_op[1]) begin
      if (md_op[0])
        prod = {32'b0, rs_val} * {32'b0, rt_val};
      else
        prod = {{32{rs_val[31]}}, rs_val} *
               {{32{rt_val[31]}}, rt_val};
      {res_hi, res_lo} = prod;
    end else if (rt_val == 32'b0) begin
      res_lo = '1;
      res_hi = rs_val;
    end else begin
      ua = (sgn & rs_val[31]) ? -rs_val : rs_val;
      ub = (sgn & rt_val[31]) ? -rt_val : rt_val;
      uq = ua / ub;
      ur = ua % ub;
      res_lo = (sgn & (rs_val[31] ^ rt_val[31])) ? -uq : uq;
      res_hi = (sgn & rs_val[31]) ? -ur : ur;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: leave IDLE on a real MD op, return when the count expires.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_md) state_nx = BUSY;
      BUSY: if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, countdown, HI/LO writes and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= md_op[1] ? CW'(DIV_CYCLES - 1)
                                : CW'(MULT_CYCLES - 1);
          end else if (is_mthi) begin
            HI <= rs_val;
          end else if (is_mtlo) begin
            LO <= rs_val;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            HI   <= pend_hi;
            LO   <= pend_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: stall covers the issue cycle so a following mfhi/mflo waits.
  always_comb begin
    busy     = (state == BUSY);
    stall_md = md_use_D & (busy | start_md);
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl.
// Directed spec cases followed by random ops against a reference model.
module tb_md_hilo_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_use_D = 1'b0;
  logic        busy;
  logic        done;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_hilo_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .md_op(md_op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .md_use_D(md_use_D),
    .busy(busy),
    .done(done),
    .stall_md(stall_md),
    .HI(HI),
    .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural effect of one op on HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    longint          p;
    longint unsigned up;
    int              sa;
    int              sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        {exp_hi, exp_lo} = p;
      end
      3'd1: begin
        up = longint'(a) * longint'(b);
        {exp_hi, exp_lo} = up;
      end
      3'd2: begin
        if (b == 0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000;
          exp_hi = 32'h0;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      3'd3: begin
        if (b == 0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = a;
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue a mult/div and follow it through its busy window.
  // inject >= 0 offers an mtlo at that busy cycle, which must be ignored.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
    int n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    n = op[1] ? DC : MC;
    old_hi = exp_hi;
    old_lo = exp_lo;
    start = 1'b1;
    md_op = op;
    rs_val = a;
    rt_val = b;
    #1;
    if (md_use_D) chk1("stall_issue", stall_md, 1'b1);
    tick;
    start = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    model(op, a, b);
    for (int i = 0; i < n; i++) begin
      chk1("busy_in", busy, 1'b1);
      chk1("done_in", done, 1'b0);
      chk32("hi_hold", HI, old_hi);
      chk32("lo_hold", LO, old_lo);
      if (md_use_D) chk1("stall_busy", stall_md, 1'b1);
      if (i == inject) begin
        start = 1'b1;
        md_op = 3'b101;
        rs_val = 32'h5555_AAAA;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    start = 1'b0;
    chk1("busy_end", busy, 1'b0);
    chk1("done_pulse", done, 1'b1);
    chk32("hi_res", HI, exp_hi);
    chk32("lo_res", LO, exp_lo);
    if (md_use_D) chk1("stall_end", stall_md, 1'b0);
    tick;
    chk1("done_clear", done, 1'b0);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1;
    md_op = op;
    rs_val = a;
    rt_val = $urandom;
    tick;
    start = 1'b0;
    model(op, a, 32'h0);
    chk32("mt_hi", HI, exp_hi);
    chk32("mt_lo", LO, exp_lo);
    chk1("mt_busy", busy, 1'b0);
    chk1("mt_done", done, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    tick;
    tick;
    chk32("rst_hi", HI, 32'h0);
    chk32("rst_lo", LO, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick;

    run_md(3'd0, 32'hFFFF_FFFF, 32'h2, -1);
    chk32("t1_hi", HI, 32'hFFFF_FFFF);
    chk32("t1_lo", LO, 32'hFFFF_FFFE);

    run_md(3'd1, 32'hFFFF_FFFF, 32'h2, -1);
    chk32("t2_hi", HI, 32'h0000_0001);
    chk32("t2_lo", LO, 32'hFFFF_FFFE);

    run_md(3'd2, 32'hFFFF_FFF9, 32'h2, -1);
    chk32("t3_hi", HI, 32'hFFFF_FFFF);
    chk32("t3_lo", LO, 32'hFFFF_FFFD);

    run_md(3'd3, 32'hFFFF_FFF9, 32'h2, -1);
    chk32("t3u_hi", HI, 32'h0000_0001);
    chk32("t3u_lo", LO, 32'h7FFF_FFFC);

    run_md(3'd3, 32'h0000_1234, 32'h0, -1);
    chk32("t4_hi", HI, 32'h0000_1234);
    chk32("t4_lo", LO, 32'hFFFF_FFFF);

    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk32("t4o_hi", HI, 32'h0);
    chk32("t4o_lo", LO, 32'h8000_0000);

    run_mt(3'd4, 32'hCAFE_0000);
    chk32("t5_hi", HI, 32'hCAFE_0000);

    md_use_D = 1'b1;
    #1;
    chk1("stall_idle", stall_md, 1'b0);
    run_md(3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 2);
    md_use_D = 1'b0;

    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (op < 3'd4) begin
        run_md(op, a, b, -1);
      end else begin
        run_mt(op, a);
      end
    end

    start = 1'b1;
    md_op = 3'd2;
    rs_val = 32'h0000_0064;
    rt_val = 32'h0000_0007;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk32("arst_hi", HI, 32'h0);
    chk32("arst_lo", LO, 32'h0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DC + 2; i++) begin
      tick;
      chk1("post_done", done, 1'b0);
      chk1("post_busy", busy, 1'b0);
      chk32("post_hi", HI, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
